multiplicador_booth: RTL

//  Sequential signed (optionally unsigned) radix-2 Booth multiplier for the MIPS datapath.
//  It is the multiply counterpart of the shift-subtract divider unit and uses the same

---
 rtl/multiplicador_booth.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/multiplicador_booth.sv
// multiplicador_booth
//   Sequential radix-2 Booth multiplier for the MIPS datapath (mult/multu).
//   Uses the same START/END pulse protocol as the divider unit. One Booth
//   step per clock over WIDTH+1 bits, then a single write of the 2*WIDTH
//   product into HI/LO together with a one-cycle MULT_END pulse.
//   Latency is fixed: MULT_END is high in the cycle after the 34th edge
//   following the START edge (WIDTH=32).
//
//   Optional feature macro: MULT_UNSIGNED_EN
//     defined   -> MULT_U port exists; MULT_U=1 zero-extends operands (multu)
//     undefined -> signed multiply only
//
// Ports
//   clock       in   1      rising-edge clock
//   reset       in   1      synchronous, active-high reset
//   MULT_START  in   1      request pulse; A/B (and MULT_U) sampled on this edge
//   MULT_U      in   1      unsigned select (only with MULT_UNSIGNED_EN)
//   A           in   WIDTH  multiplicand
//   B           in   WIDTH  multiplier
//   MULT_BUSY   out  1      state != IDLE
//   MULT_END    out  1      one-cycle pulse; HI/LO valid from this edge on
//   HI          out  WIDTH  upper half of product
//   LO          out  WIDTH  lower half of product
module multiplicador_booth #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             MULT_START,
`ifdef MULT_UNSIGNED_EN
    input  logic             MULT_U,
`endif
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             MULT_BUSY,
    output logic             MULT_END,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned W1 = WIDTH + 1;
    localparam int unsigned CW = $clog2(W1 + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [W1-1:0]   m_q, m_d;
    logic [W1-1:0]   acc_q, acc_d;
    logic [W1-1:0]   q_q, q_d;
    logic            q1_q, q1_d;
    logic            end_q, end_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic            ext_a, ext_b;
    logic [W1-1:0]   sum;

    // Extension bit for the W1-bit internal operands.
    always_comb begin
`ifdef MULT_UNSIGNED_EN
        ext_a = MULT_U ? 1'b0 : A[WIDTH-1];
        ext_b = MULT_U ? 1'b0 : B[WIDTH-1];
`else
        ext_a = A[WIDTH-1];
        ext_b = B[WIDTH-1];
`endif
    end

    // Booth recoding of {Q[0], q_1}: 01 adds M, 10 subtracts M.
    always_comb begin
        sum = acc_q;
        case ({q_q[0], q1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        end_d   = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        // START wins in every state, including the DONE write edge, so an
        // aborted or overtaken operation never raises MULT_END.
        if (MULT_START) begin
            m_d     = {ext_a, A};
            q_d     = {ext_b, B};
            q1_d    = 1'b0;
            acc_d   = '0;
            count_d = '0;
            hi_d    = '0;
            lo_d    = '0;
            state_d = S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    // Arithmetic right shift of {sum, Q, q_1}.
                    acc_d   = {sum[W1-1], sum[W1-1:1]};
                    q_d     = {sum[0], q_q[W1-1:1]};
                    q1_d    = q_q[0];
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(W1 - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // {ACC,Q} is 2*W1 bits; the product is its low 2*WIDTH bits.
                    hi_d    = {acc_q[WIDTH-2:0], q_q[W1-1]};
                    lo_d    = q_q[WIDTH-1:0];
                    end_d   = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            end_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            end_q   <= end_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign MULT_BUSY = (state_q != S_IDLE);
    assign MULT_END  = end_q;
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule
